// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared types and defaults for the EXE/MEM pipeline register.
//   pipe_bundle_t : EXE-side instruction fields as presented to the register
//   mem_stage_t   : registered contents driven towards the memory stage
//   wait_state_e  : per-access wait watchdog states
package exe_mem_stage_reg_pkg;

  localparam int unsigned BaseAddrDefault = 1024;
  localparam int unsigned MaxWaitDefault  = 255;
  localparam int unsigned WaitWDefault    = 8;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [4:0]  dest;
  } pipe_bundle_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic [31:0] address;
    logic [31:0] data;
    logic [4:0]  dest;
    logic [31:0] alu_result;
  } mem_stage_t;

  typedef enum logic {StIdle, StWait} wait_state_e;

  // Word accesses only: any low address bit set is a misaligned access.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/exe_mem_stage_reg_if.sv
// EXE -> EXE/MEM register handshake bundle.
//   master : EXE stage (drives instruction fields and flush, sees exe_stall)
//   slave  : EXE/MEM register (consumes the fields, drives exe_stall)
interface exe_mem_stage_reg_if;
  logic        exe_valid;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic        exe_mem_w_en;
  logic [31:0] exe_alu_result;
  logic [31:0] exe_st_val;
  logic [4:0]  exe_dest;
  logic        flush;
  logic        exe_stall;

  modport master (
    output exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    output exe_alu_result, exe_st_val, exe_dest, flush,
    input  exe_stall
  );

  modport slave (
    input  exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    input  exe_alu_result, exe_st_val, exe_dest, flush,
    output exe_stall
  );
endinterface

// File: rtl/exe_mem_stage_reg_watchdog.sv
// mem_wait_watchdog: counts freeze cycles of one memory access and raises a
// sticky timeout once a single access has been frozen for MAX_WAIT cycles.
//   clk, rst      : clock, synchronous active-low reset
//   freeze_i      : memory stage busy
//   mem_active_i  : registered access is a load or store
//   timeout_err_o : sticky timeout flag
module mem_wait_watchdog
  import exe_mem_stage_reg_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MaxWaitDefault,
  parameter int unsigned WAIT_W   = WaitWDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze_i,
  input  logic mem_active_i,
  output logic timeout_err_o
);

  localparam logic [WAIT_W-1:0] CntLimit = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] CntOne   = WAIT_W'(1);

  wait_state_e       state_d, state_q;
  logic [WAIT_W-1:0] cnt_d, cnt_q;
  logic              err_d, err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        // The entering freeze cycle is already the first counted one.
        if (freeze_i && mem_active_i) begin
          state_d = StWait;
          cnt_d   = CntOne;
          if (MAX_WAIT == 1) err_d = 1'b1;
        end
      end
      StWait: begin
        if (!freeze_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLimit) err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign timeout_err_o = err_q;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE/MEM pipeline register feeding the memory stage.
//   clk, rst        : clock, synchronous active-low reset
//   exe             : EXE-side instruction fields, flush, exe_stall (slave)
//   freeze          : memory stage busy; holds all registered outputs
//   MEMread/MEMwrite, address, data : memory-stage request (address rebased)
//   mem_wb_en, mem_dest, mem_alu_result : write-back fields
//   misalign_err, timeout_err : sticky error flags
//   stall_cycles    : free-running count of frozen cycles
module exe_mem_stage_reg
  import exe_mem_stage_reg_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BaseAddrDefault,
  parameter int unsigned MAX_WAIT  = MaxWaitDefault,
  parameter int unsigned WAIT_W    = WaitWDefault
) (
  input  logic                      clk,
  input  logic                      rst,
  exe_mem_stage_reg_if.slave        exe,
  input  logic                      freeze,
  output logic                      MEMread,
  output logic                      MEMwrite,
  output logic [31:0]               address,
  output logic [31:0]               data,
  output logic                      mem_wb_en,
  output logic [4:0]                mem_dest,
  output logic [31:0]               mem_alu_result,
  output logic                      misalign_err,
  output logic                      timeout_err,
  output logic [31:0]               stall_cycles
);

  pipe_bundle_t exe_b;
  logic [31:0]  exe_addr;
  logic         squash;
  logic         misalign;

  mem_stage_t   stage_d, stage_q;
  logic         pending_flush_d, pending_flush_q;
  logic         misalign_err_d, misalign_err_q;
  logic [31:0]  stall_cycles_d, stall_cycles_q;

  assign exe_b = '{wb_en:      exe.exe_wb_en,
                   mem_r_en:   exe.exe_mem_r_en,
                   mem_w_en:   exe.exe_mem_w_en,
                   alu_result: exe.exe_alu_result,
                   st_val:     exe.exe_st_val,
                   dest:       exe.exe_dest};

  assign exe_addr = exe_b.alu_result - 32'(BASE_ADDR);
  // A flush that arrived while frozen squashes the next capture instead.
  assign squash   = !exe.exe_valid || exe.flush || pending_flush_q;
  assign misalign = !squash && (exe_b.mem_r_en || exe_b.mem_w_en) && is_misaligned(exe_addr);

  always_comb begin
    stage_d         = stage_q;
    pending_flush_d = pending_flush_q;
    misalign_err_d  = misalign_err_q;
    stall_cycles_d  = stall_cycles_q;
    if (freeze) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
      if (exe.flush) pending_flush_d = 1'b1;
    end else begin
      pending_flush_d = 1'b0;
      if (squash || misalign) begin
        stage_d = '0;
      end else begin
        stage_d = '{mem_read:   exe_b.mem_r_en && !exe_b.mem_w_en,
                    mem_write:  exe_b.mem_w_en,
                    wb_en:      exe_b.wb_en,
                    address:    exe_addr,
                    data:       exe_b.st_val,
                    dest:       exe_b.dest,
                    alu_result: exe_b.alu_result};
      end
      if (misalign) misalign_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q         <= '0;
      pending_flush_q <= 1'b0;
      misalign_err_q  <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      stage_q         <= stage_d;
      pending_flush_q <= pending_flush_d;
      misalign_err_q  <= misalign_err_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  mem_wait_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .freeze_i      (freeze),
    .mem_active_i  (stage_q.mem_read || stage_q.mem_write),
    .timeout_err_o (timeout_err)
  );

  assign exe.exe_stall    = freeze;
  assign MEMread          = stage_q.mem_read;
  assign MEMwrite         = stage_q.mem_write;
  assign address          = stage_q.address;
  assign data             = stage_q.data;
  assign mem_wb_en        = stage_q.wb_en;
  assign mem_dest         = stage_q.dest;
  assign mem_alu_result   = stage_q.alu_result;
  assign misalign_err     = misalign_err_q;
  assign stall_cycles     = stall_cycles_q;

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
module tb_exe_mem_stage_reg;

  localparam int unsigned BaseAddr = 1024;
  localparam int unsigned MaxWait  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        MEMread, MEMwrite, mem_wb_en, misalign_err, timeout_err;
  logic [31:0] address, data, mem_alu_result, stall_cycles;
  logic [4:0]  mem_dest;

  exe_mem_stage_reg_if ex_if ();

  exe_mem_stage_reg #(
    .BASE_ADDR (BaseAddr),
    .MAX_WAIT  (MaxWait),
    .WAIT_W    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .exe            (ex_if.slave),
    .freeze         (freeze),
    .MEMread        (MEMread),
    .MEMwrite       (MEMwrite),
    .address        (address),
    .data           (data),
    .mem_wb_en      (mem_wb_en),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .misalign_err   (misalign_err),
    .timeout_err    (timeout_err),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the memory stage should be seeing.
  logic        m_read, m_write, m_wb, m_mis, m_to, m_pend;
  logic [31:0] m_addr, m_data, m_alu, m_stall;
  logic [4:0]  m_dest;
  int          m_frozen_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] st, input logic [4:0] d,
                       input logic fl, input logic fr);
    ex_if.exe_valid      = v;
    ex_if.exe_wb_en      = wb;
    ex_if.exe_mem_r_en   = r;
    ex_if.exe_mem_w_en   = w;
    ex_if.exe_alu_result = alu;
    ex_if.exe_st_val     = st;
    ex_if.exe_dest       = d;
    ex_if.flush          = fl;
    freeze               = fr;
  endtask

  task automatic model_clear();
    {m_read, m_write, m_wb, m_mis, m_to, m_pend} = '0;
    m_addr = 0; m_data = 0; m_alu = 0; m_stall = 0; m_dest = 0;
    m_frozen_run = 0;
  endtask

  // Advance the model by one clock with the inputs that were present at the edge.
  task automatic tick();
    logic        v, wb, r, w, fl, fr, rs;
    logic [31:0] alu, st, eff;
    logic [4:0]  d;
    v = ex_if.exe_valid; wb = ex_if.exe_wb_en; r = ex_if.exe_mem_r_en; w = ex_if.exe_mem_w_en;
    alu = ex_if.exe_alu_result; st = ex_if.exe_st_val; d = ex_if.exe_dest;
    fl = ex_if.flush; fr = freeze; rs = rst;
    @(posedge clk);
    #1;
    if (!rs) begin
      model_clear();
    end else if (fr) begin
      m_stall = m_stall + 1;
      if (fl) m_pend = 1'b1;
      if (m_read || m_write) begin
        m_frozen_run++;
        if (m_frozen_run >= MaxWait) m_to = 1'b1;
      end
    end else begin
      m_frozen_run = 0;
      eff = alu - BaseAddr;
      if (!v || fl || m_pend || ((r || w) && (eff % 4 != 0))) begin
        if (v && !fl && !m_pend) m_mis = 1'b1;
        {m_read, m_write, m_wb} = '0;
        m_addr = 0; m_data = 0; m_alu = 0; m_dest = 0;
      end else begin
        m_write = w;
        m_read  = r && !w;
        m_wb    = wb;
        m_addr  = eff;
        m_data  = st;
        m_alu   = alu;
        m_dest  = d;
      end
      m_pend = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".MEMread"},  32'(MEMread),   32'(m_read));
    chk({tag, ".MEMwrite"}, 32'(MEMwrite),  32'(m_write));
    chk({tag, ".wb_en"},    32'(mem_wb_en), 32'(m_wb));
    chk({tag, ".address"},  address,        m_addr);
    chk({tag, ".data"},     data,           m_data);
    chk({tag, ".dest"},     32'(mem_dest),  32'(m_dest));
    chk({tag, ".alu"},      mem_alu_result, m_alu);
    chk({tag, ".misalign"}, 32'(misalign_err), 32'(m_mis));
    chk({tag, ".timeout"},  32'(timeout_err),  32'(m_to));
    chk({tag, ".stalls"},   stall_cycles,   m_stall);
    chk({tag, ".stall"},    32'(ex_if.exe_stall), 32'(freeze));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        v, wb, r, w;
    logic [31:0] alu, st;
    logic [4:0]  d;
    logic        fl;
    logic        e_read, e_write, e_wb;
    logic [31:0] e_addr, e_data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic wb, input logic r, input logic w,
                              input logic [31:0] alu, input logic [31:0] st,
                              input logic [4:0] d, input logic fl, input logic er,
                              input logic ew, input logic ewb, input logic [31:0] ea,
                              input logic [31:0] ed);
    vec_t x;
    x.v = v; x.wb = wb; x.r = r; x.w = w; x.alu = alu; x.st = st; x.d = d; x.fl = fl;
    x.e_read = er; x.e_write = ew; x.e_wb = ewb; x.e_addr = ea; x.e_data = ed;
    return x;
  endfunction

  vec_t vecs[8];

  initial begin
    logic        hold_read;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] alu_r;

    vecs[0] = mk(1, 1, 1, 0, 32'd1032, 32'h11, 5'd3, 0, 1, 0, 1, 32'd8, 32'h11);
    vecs[1] = mk(1, 0, 0, 1, 32'd2048, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0, 32'd1024, 32'hDEADBEEF);
    vecs[2] = mk(1, 0, 1, 1, 32'd1040, 32'h5, 5'd1, 0, 0, 1, 0, 32'd16, 32'h5);
    vecs[3] = mk(0, 1, 1, 0, 32'd1032, 32'h7, 5'd2, 0, 0, 0, 0, 32'd0, 32'd0);
    vecs[4] = mk(1, 1, 1, 0, 32'd1032, 32'h7, 5'd2, 1, 0, 0, 0, 32'd0, 32'd0);
    vecs[5] = mk(1, 1, 0, 0, 32'd7, 32'h9, 5'd9, 0, 0, 0, 1, 32'hFFFFFC07, 32'h9);
    vecs[6] = mk(1, 1, 1, 0, 32'd0, 32'h3, 5'd4, 0, 1, 0, 1, 32'hFFFFFC00, 32'h3);
    vecs[7] = mk(1, 1, 1, 0, 32'd1025, 32'h3, 5'd4, 0, 0, 0, 0, 32'd0, 32'd0);

    // Reset while frozen.
    do_reset();
    check_model("reset");
    chk("reset.stall_cycles", stall_cycles, 32'd0);
    chk("reset.MEMread", 32'(MEMread), 32'd0);

    // Table of single-cycle advances.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].wb, vecs[i].r, vecs[i].w, vecs[i].alu, vecs[i].st,
            vecs[i].d, vecs[i].fl, 1'b0);
      tick();
      chk($sformatf("vec%0d.MEMread", i),  32'(MEMread),   32'(vecs[i].e_read));
      chk($sformatf("vec%0d.MEMwrite", i), 32'(MEMwrite),  32'(vecs[i].e_write));
      chk($sformatf("vec%0d.wb_en", i),    32'(mem_wb_en), 32'(vecs[i].e_wb));
      chk($sformatf("vec%0d.address", i),  address,        vecs[i].e_addr);
      chk($sformatf("vec%0d.data", i),     data,           vecs[i].e_data);
      check_model($sformatf("vec%0d", i));
    end
    chk("vec.misalign_sticky", 32'(misalign_err), 32'd1);

    // Load then five frozen cycles with EXE inputs churning.
    do_reset();
    drive(1, 1, 1, 0, 32'd1032, 32'hAB, 5'd6, 0, 0);
    tick();
    chk("load.MEMread", 32'(MEMread), 32'd1);
    chk("load.address", address, 32'd8);
    hold_read = MEMread; hold_addr = address; hold_data = data;
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, 1), 0, 1, $urandom, $urandom, 5'($urandom), 0, 1);
      tick();
      chk("hold.MEMread", 32'(MEMread), 32'(hold_read));
      chk("hold.address", address, hold_addr);
      chk("hold.data", data, hold_data);
      chk("hold.exe_stall", 32'(ex_if.exe_stall), 32'd1);
      check_model("hold");
    end
    chk("hold.stall_cycles", stall_cycles, 32'd5);

    // Flush during freeze squashes the next capture only.
    do_reset();
    drive(1, 1, 1, 0, 32'd1036, 32'h0, 5'd7, 0, 0);
    tick();
    drive(1, 1, 1, 0, 32'd1036, 32'h0, 5'd7, 0, 1);
    tick();
    drive(1, 1, 1, 0, 32'd1036, 32'h0, 5'd7, 1, 1);
    tick();
    chk("flush.inflight", 32'(MEMread), 32'd1);
    drive(1, 1, 1, 0, 32'd1036, 32'h0, 5'd7, 0, 1);
    tick();
    drive(1, 1, 1, 0, 32'd1040, 32'h0, 5'd8, 0, 0);
    tick();
    chk("flush.bubble_rd", 32'(MEMread), 32'd0);
    chk("flush.bubble_wb", 32'(mem_wb_en), 32'd0);
    check_model("flush");
    drive(1, 1, 1, 0, 32'd1044, 32'h0, 5'd9, 0, 0);
    tick();
    chk("flush.next_rd", 32'(MEMread), 32'd1);
    chk("flush.next_addr", address, 32'd20);
    check_model("flush_next");

    // Misaligned store.
    do_reset();
    drive(1, 0, 0, 1, 32'd1026, 32'h55, 5'd0, 0, 0);
    tick();
    chk("mis.MEMwrite", 32'(MEMwrite), 32'd0);
    chk("mis.err", 32'(misalign_err), 32'd1);
    drive(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("mis.sticky", 32'(misalign_err), 32'd1);
    check_model("mis");

    // Watchdog: 3 frozen cycles is fine, 4 trips it.
    do_reset();
    drive(1, 0, 0, 1, 32'd2048, 32'h1, 5'd0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 32'd2052, 32'h2, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("wd.three", 32'(timeout_err), 32'd0);
    drive(1, 0, 0, 1, 32'd2052, 32'h2, 5'd0, 0, 0);
    tick();
    chk("wd.second_access", 32'(MEMwrite), 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("wd.before_four", 32'(timeout_err), 32'd0);
    tick();
    chk("wd.four", 32'(timeout_err), 32'd1);
    drive(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("wd.sticky", 32'(timeout_err), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("wd.reset", 32'(timeout_err), 32'd0);
    check_model("wd");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       alu_r = BaseAddr + 4 * $urandom_range(0, 255);
        1:       alu_r = BaseAddr + $urandom_range(0, 15);
        default: alu_r = $urandom;
      endcase
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), alu_r, $urandom, 5'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4);
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
